// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl
//  Description : Time-multiplexed scan sequencer for a 4-digit display.
//                Drives the select/enable of a 2-to-4 digit-strobe decoder
//                and presents the selected digit value to the segment path.
//                The digit word is latched once per frame; an optional
//                blanking gap separates consecutive digits.
//  Config      : LEADING_ZERO_BLANK_EN - suppress leading-zero digits
//                (digit 0 is always shown).
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 100,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] digits,
  output logic [1:0]  sel,
  output logic        dec_en,
  output logic [3:0]  digit_val,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [15:0]      r_shadow, w_shadow_nxt;
  logic             r_dec_en, w_dec_en_nxt;
  logic [3:0]       r_digit_val, w_digit_val_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_digit_end;

  // Nibble i of a 16-bit digit word.
  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  // Whether digit i of the latched word is strobed while it is selected.
  function automatic logic show_en(input logic [15:0] w, input logic [1:0] i);
`ifdef LEADING_ZERO_BLANK_EN
    case (i)
      2'd0:    return 1'b1;
      2'd1:    return |w[15:4];
      2'd2:    return |w[15:8];
      default: return |w[15:12];
    endcase
`else
    return 1'b1 | (|w) | (|i);
`endif
  endfunction

  // State, counter, shadow word and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_shadow     <= 16'h0000;
      r_dec_en     <= 1'b0;
      r_digit_val  <= 4'h0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_shadow     <= w_shadow_nxt;
      r_dec_en     <= w_dec_en_nxt;
      r_digit_val  <= w_digit_val_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sel_nxt        = r_sel;
    w_shadow_nxt     = r_shadow;
    w_dec_en_nxt     = r_dec_en;
    w_digit_val_nxt  = r_digit_val;
    w_frame_done_nxt = 1'b0;
    w_busy_nxt       = r_busy;
    w_digit_end      = 1'b0;

    case (r_state)
      IDLE: begin
        w_dec_en_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        if (run) begin
          w_shadow_nxt    = digits;
          w_sel_nxt       = 2'd0;
          w_cnt_nxt       = '0;
          w_state_nxt     = SHOW;
          w_dec_en_nxt    = 1'b1;
          w_digit_val_nxt = digits[3:0];
          w_busy_nxt      = 1'b1;
        end
      end
      SHOW: begin
        if (r_cnt == c_dwell_last) begin
          w_cnt_nxt = '0;
          if (BLANK_CYC > 0) begin
            w_state_nxt  = BLANK;
            w_dec_en_nxt = 1'b0;
          end else begin
            w_digit_end = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_cnt_nxt   = '0;
          w_digit_end = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // End of one digit's dwell (and gap): advance, or close the frame.
    if (w_digit_end) begin
      if (r_sel != 2'd3) begin
        w_sel_nxt       = r_sel + 2'd1;
        w_state_nxt     = SHOW;
        w_dec_en_nxt    = show_en(r_shadow, r_sel + 2'd1);
        w_digit_val_nxt = nib(r_shadow, r_sel + 2'd1);
      end else begin
        w_sel_nxt        = 2'd0;
        w_frame_done_nxt = 1'b1;
        if (run) begin
          w_shadow_nxt    = digits;
          w_state_nxt     = SHOW;
          w_dec_en_nxt    = 1'b1;
          w_digit_val_nxt = digits[3:0];
        end else begin
          w_state_nxt  = IDLE;
          w_dec_en_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      end
    end
  end

  assign sel        = r_sel;
  assign dec_en     = r_dec_en;
  assign digit_val  = r_digit_val;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan_ctrl
//  Description : Scoreboard bench for digit_scan_ctrl. Two instances run on
//                shared stimulus: one with a blanking gap, one without. A
//                frame-position reference model queues the expected outputs
//                of every cycle; a monitor pops and compares on the falling
//                edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_ctrl;

  localparam int c_dwell   = 4;
  localparam int c_blank_a = 2;
  localparam int c_blank_b = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic [3:0] val;
    logic       fd;
    logic       busy;
    logic       chkval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] digits = 16'h0000;

  logic [1:0] sel_a, sel_b;
  logic       en_a, en_b, fd_a, fd_b, busy_a, busy_b;
  logic [3:0] val_a, val_b;

  int checks = 0;
  int passed = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state, one entry per instance.
  bit          m_scan[2];
  int          m_pos[2];
  logic [15:0] m_word[2];
  logic [3:0]  m_val[2];
  bit          m_vk[2];

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DWELL_CYC(c_dwell), .BLANK_CYC(c_blank_a), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .run(run), .digits(digits),
    .sel(sel_a), .dec_en(en_a), .digit_val(val_a), .frame_done(fd_a), .busy(busy_a)
  );

  digit_scan_ctrl #(.DWELL_CYC(c_dwell), .BLANK_CYC(c_blank_b), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .run(run), .digits(digits),
    .sel(sel_b), .dec_en(en_b), .digit_val(val_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Highest non-zero nibble index of a word (0 when the word is zero).
  function automatic int top_digit(input logic [15:0] w);
    int t = 0;
    for (int i = 0; i < 4; i++) if (((w >> (4 * i)) & 16'hF) != 0) t = i;
    return t;
  endfunction

  // One clock edge of the model: position within a frame of 4*(D+B) cycles.
  task automatic model_step(input int k, input int d, input int b);
    exp_t e;
    int   per, len, idx, off;
    per = d + b;
    len = 4 * per;
    e = '0;
    if (rst) begin
      m_scan[k] = 0; m_val[k] = 4'h0; m_vk[k] = 1;
    end else if (!m_scan[k]) begin
      if (run) begin
        m_scan[k] = 1; m_pos[k] = 0; m_word[k] = digits;
      end
    end else begin
      m_pos[k]++;
      if (m_pos[k] == len) begin
        e.fd = 1'b1;
        if (run) begin
          m_pos[k] = 0; m_word[k] = digits;
        end else begin
          m_scan[k] = 0; m_vk[k] = 0;
        end
      end
    end
    if (m_scan[k]) begin
      idx = m_pos[k] / per;
      off = m_pos[k] % per;
      m_val[k] = 4'((m_word[k] >> (4 * idx)) & 16'hF);
      m_vk[k]  = 1;
      e.sel  = 2'(idx);
      e.en   = (off < d);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > top_digit(m_word[k])) e.en = 1'b0;
`endif
      e.busy = 1'b1;
    end
    e.val    = m_val[k];
    e.chkval = m_vk[k];
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic compare(input int k, input exp_t e, input logic [1:0] s, input logic en,
                         input logic [3:0] v, input logic fd, input logic bz);
    logic [8:0] act, req;
    act = {s, en, (e.chkval ? v : 4'h0), fd, bz};
    req = {e.sel, e.en, (e.chkval ? e.val : 4'h0), e.fd, e.busy};
    checks++;
    if (act === req) passed++;
    else $display("FAIL dut%0d outputs t=%0t got sel/en/val/fd/busy=%h required=%h",
                  k, $time, act, req);
  endtask

  // Model: sample inputs at every rising edge and queue expected outputs.
  initial begin
    forever begin
      @(posedge clk);
      model_step(0, c_dwell, c_blank_a);
      model_step(1, c_dwell, c_blank_b);
    end
  end

  // Monitor: pop and compare away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        compare(0, e, sel_a, en_a, val_a, fd_a, busy_a);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        compare(1, e, sel_b, en_b, val_b, fd_b, busy_b);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       return w;
      1:       return w & 16'h00FF;
      2:       return w & 16'h0FFF;
      default: return w & 16'h000F;
    endcase
  endfunction

  // Directed scenarios followed by randomized traffic.
  initial begin
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(2);
    run = 1'b1; digits = 16'h1234;
    idle_cycles(30);
    digits = 16'hABCD;
    idle_cycles(40);
    idle_cycles(6);
    run = 1'b0;
    idle_cycles(40);
    run = 1'b1;
    idle_cycles(14);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(30);
    digits = 16'h0050;
    idle_cycles(60);
    digits = 16'h0000;
    idle_cycles(30);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)   digits = rand_digits();
      if ($urandom_range(0, 39) == 0)  run = ~run;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    run = 1'b0;
    idle_cycles(40);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
